sc_lane_scroll_ctrl: RTL

SC_LANE_SCROLL_CTRL -- requirements
Module: sc_lane_scroll_ctrl

---
 rtl/sc_lane_scroll_pkg.sv | 42 ++++
 rtl/sc_lane_scroll_timer.sv | 55 +++++
 rtl/sc_lane_scroll_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/sc_lane_scroll_pkg.sv
// Shared types and tables for the lane scroll controller: FSM encoding,
// per-level base timer limits and the lane shift-select codes.
package sc_lane_scroll_pkg;

    localparam int unsigned BASE_W  = 25;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned SHIFT_W = 2;
    localparam int unsigned STATE_W = 2;

    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(5);

    typedef enum logic [STATE_W-1:0] {
        ST_RESET = 2'd0,
        ST_CHECK = 2'd1,
        ST_RUN   = 2'd2,
        ST_PAUSE = 2'd3
    } state_e;

    localparam logic [SHIFT_W-1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [SHIFT_W-1:0] SHIFT_LEFT  = 2'b10;
    localparam logic [SHIFT_W-1:0] SHIFT_RIGHT = 2'b01;

    // Unshifted timer limit for a latched level; level 0 never runs the timers.
    function automatic logic [BASE_W-1:0] base_limit(input logic [LVL_W-1:0] lvl);
        logic [BASE_W-1:0] lim;
        lim = '0;
        case (lvl)
            3'd1:    lim = 25'h1FFFFFF;
            3'd2:    lim = 25'h1E00000;
            3'd3:    lim = 25'h1800000;
            3'd4:    lim = 25'h1000000;
            3'd5:    lim = 25'h0FFFFFF;
            default: lim = '0;
        endcase
        return lim;
    endfunction

    function automatic logic [LVL_W-1:0] sat_level(input logic [LVL_W-1:0] lvl);
        return (lvl > LVL_MAX) ? LVL_MAX : lvl;
    endfunction

endpackage

// File: rtl/sc_lane_scroll_timer.sv
// One scroll lane: free-running limit counter with a registered shift pulse
// and direction code produced the cycle after the counter hits its limit.
module sc_lane_scroll_timer
    import sc_lane_scroll_pkg::*;
#(
    parameter int unsigned CNT_W = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cnt_en,
    input  logic               cnt_clr,
    input  logic               tick_en,
    input  logic               dir,
    input  logic [CNT_W-1:0]   limit,
    output logic               tick,
    output logic [SHIFT_W-1:0] shift
);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick_q, tick_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               match_c;

    always_comb begin
        match_c = cnt_en && (cnt_q == limit);
        cnt_d   = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = match_c ? '0 : cnt_q + CNT_W'(1);
        end
        // A match is only turned into a shift when the lane keeps running.
        tick_d  = match_c && tick_en;
        shift_d = SHIFT_HOLD;
        if (tick_d) begin
            shift_d = dir ? SHIFT_LEFT : SHIFT_RIGHT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            shift_q <= SHIFT_HOLD;
        end else begin
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            shift_q <= shift_d;
        end
    end

    assign tick  = tick_q;
    assign shift = shift_q;

endmodule

// File: rtl/sc_lane_scroll_ctrl.sv
// Multi-lane scroll controller: level/pause FSM driving LANES lane timers.
// Define SC_LANE_SCROLL_CTRL_STAGGER_EN to stagger lane limits by B>>3 per lane.
module sc_lane_scroll_ctrl
    import sc_lane_scroll_pkg::*;
#(
    parameter int unsigned LANES       = 4,
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned LIMIT_SHIFT = 0
) (
    input  logic                 SC_LANE_SCROLL_CTRL_CLOCK_50,
    input  logic                 SC_LANE_SCROLL_CTRL_RESET_InLow,
    input  logic [LVL_W-1:0]     SC_LANE_SCROLL_CTRL_level_InBus,
    input  logic                 SC_LANE_SCROLL_CTRL_pause_InLow,
    input  logic [LANES-1:0]     SC_LANE_SCROLL_CTRL_dir_InBus,
    output logic                 SC_LANE_SCROLL_CTRL_clear_OutLow,
    output logic [2*LANES-1:0]   SC_LANE_SCROLL_CTRL_shiftselection_OutBus,
    output logic [LANES-1:0]     SC_LANE_SCROLL_CTRL_tick_OutBus,
    output logic [STATE_W-1:0]   SC_LANE_SCROLL_CTRL_state_OutBus
);

    logic clk;
    logic rst_n;
    assign clk   = SC_LANE_SCROLL_CTRL_CLOCK_50;
    assign rst_n = SC_LANE_SCROLL_CTRL_RESET_InLow;

    state_e           state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             clear_q, clear_d;
    logic [LVL_W-1:0] lvl_sat_c;
    logic             run_c;
    logic             clr_c;
    logic             fire_c;
    logic [CNT_W-1:0] base_c;

    assign lvl_sat_c = sat_level(SC_LANE_SCROLL_CTRL_level_InBus);

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        case (state_q)
            ST_RESET: begin
                if (SC_LANE_SCROLL_CTRL_level_InBus != '0) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                lvl_d   = lvl_sat_c;
                state_d = (SC_LANE_SCROLL_CTRL_level_InBus == '0) ? ST_RESET : ST_RUN;
            end
            ST_RUN, ST_PAUSE: begin
                // Saturated comparison keeps 6/7 from retriggering CHECK against a latched 5.
                if (SC_LANE_SCROLL_CTRL_level_InBus == '0) begin
                    state_d = ST_RESET;
                end else if (lvl_sat_c != lvl_q) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = SC_LANE_SCROLL_CTRL_pause_InLow ? ST_RUN : ST_PAUSE;
                end
            end
            default: state_d = ST_RESET;
        endcase
        clear_d = (state_d != ST_RESET);
        run_c   = (state_q == ST_RUN);
        clr_c   = (state_q == ST_CHECK) || (state_q == ST_RESET);
        fire_c  = run_c && (state_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            lvl_q   <= '0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            clear_q <= clear_d;
        end
    end

    assign base_c = CNT_W'(base_limit(lvl_q)) >> LIMIT_SHIFT;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [CNT_W-1:0] limit_c;
`ifdef SC_LANE_SCROLL_CTRL_STAGGER_EN
        assign limit_c = base_c - CNT_W'(i) * (base_c >> 3);
`else
        assign limit_c = base_c;
`endif
        sc_lane_scroll_timer #(
            .CNT_W (CNT_W)
        ) u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .cnt_en  (run_c),
            .cnt_clr (clr_c),
            .tick_en (fire_c),
            .dir     (SC_LANE_SCROLL_CTRL_dir_InBus[i]),
            .limit   (limit_c),
            .tick    (SC_LANE_SCROLL_CTRL_tick_OutBus[i]),
            .shift   (SC_LANE_SCROLL_CTRL_shiftselection_OutBus[2*i +: 2])
        );
    end

    assign SC_LANE_SCROLL_CTRL_clear_OutLow = clear_q;
    assign SC_LANE_SCROLL_CTRL_state_OutBus = state_q;

endmodule
